// File: rtl/regfile_sb.sv
// Parametrised register file with an integrated busy-bit scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [$clog2(NREGS)-1:0]  waddr,
   input  logic [XLEN-1:0]           wdata,
   input  logic [NREAD*$clog2(NREGS)-1:0] raddr,
   output logic [NREAD*XLEN-1:0]     rdata,
   output logic [NREAD-1:0]          rbusy,
   input  logic                      issue_en,
   input  logic [$clog2(NREGS)-1:0]  issue_addr,
   output logic                      any_busy
);

   localparam int AW = $clog2(NREGS);
   localparam logic ZR = (ZERO_REG != 0);

   logic [XLEN-1:0]  rf_r [NREGS];
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic             wr_ok_s;

   assign wr_ok_s = we && !(ZR && (waddr == {AW{1'b0}}));

   // Next busy vector: a same-cycle issue beats a retiring write to the same register.
   always_comb begin
      busy_nxt_s = busy_r;
      for (int i = 0; i < NREGS; i++) begin
         if (issue_en && (issue_addr == AW'(i))) begin
            busy_nxt_s[i] = 1'b1;
         end else if (we && (waddr == AW'(i))) begin
            busy_nxt_s[i] = 1'b0;
         end else begin
            busy_nxt_s[i] = busy_r[i];
         end
      end
      if (ZR) begin
         busy_nxt_s[0] = 1'b0;
      end else begin
         busy_nxt_s[0] = busy_nxt_s[0];
      end
   end

   // Register array and scoreboard state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_r[i] <= {XLEN{1'b0}};
         end
         busy_r <= {NREGS{1'b0}};
      end else begin
         if (wr_ok_s) begin
            rf_r[waddr] <= wdata;
         end
         busy_r <= busy_nxt_s;
      end
   end

   assign any_busy = |busy_r;

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]   ra_s;
      logic [XLEN-1:0] rd_s;
      logic            rb_s;

      assign ra_s = raddr[k*AW +: AW];

      // Per-port combinational read; the zero register masks everything else.
      always_comb begin
         rd_s = rf_r[ra_s];
         rb_s = busy_r[ra_s];
`ifdef REGFILE_SB_BYPASS_EN
         if (wr_ok_s && (waddr == ra_s)) begin
            rd_s = wdata;
            rb_s = 1'b0;
         end else begin
            rd_s = rd_s;
            rb_s = rb_s;
         end
`endif
         if (ZR && (ra_s == {AW{1'b0}})) begin
            rd_s = {XLEN{1'b0}};
            rb_s = 1'b0;
         end else begin
            rd_s = rd_s;
            rb_s = rb_s;
         end
      end

      assign rdata[k*XLEN +: XLEN] = rd_s;
      assign rbusy[k]              = rb_s;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters: 32x32, two read ports, r0 hardwired).
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        any_busy;

   int n_cmp = 0;
   int n_err = 0;

   regfile_sb dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .issue_en(issue_en), .issue_addr(issue_addr), .any_busy(any_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = 5'd0; wdata = 32'h0;
      issue_en = 1'b0; issue_addr = 5'd0;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      raddr = {a1, a0};
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      raddr = 10'd0;
      step();
      step();
      reset = 1'b0;
      rd(5'd5, 5'd31);
      chk("rst_rdata0", rdata[31:0], 32'h0);
      chk("rst_rdata1", rdata[63:32], 32'h0);
      chk("rst_anybusy", {31'd0, any_busy}, 32'd0);

      // 1. write r5, mark r6 busy, then reset while another write/issue is in flight
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      issue_en = 1'b1; issue_addr = 5'd6;
      step();
      idle();
      rd(5'd5, 5'd6);
      chk("pre_rst_r5", rdata[31:0], 32'hDEADBEEF);
      chk("pre_rst_busy6", {31'd0, rbusy[1]}, 32'd1);
      reset = 1'b1;
      we = 1'b1; waddr = 5'd7; wdata = 32'h77777777;
      issue_en = 1'b1; issue_addr = 5'd8;
      step();
      reset = 1'b0;
      idle();
      rd(5'd5, 5'd6);
      chk("clr_r5", rdata[31:0], 32'h0);
      chk("clr_busy5", {31'd0, rbusy[0]}, 32'd0);
      chk("clr_busy6", {31'd0, rbusy[1]}, 32'd0);
      chk("clr_anybusy", {31'd0, any_busy}, 32'd0);
      rd(5'd7, 5'd8);
      chk("clr_r7_ignored", rdata[31:0], 32'h0);
      chk("clr_busy8_ignored", {31'd0, rbusy[1]}, 32'd0);

      // 2. basic write/read on both ports
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
      step();
      idle();
      rd(5'd7, 5'd7);
      chk("rw_p0", rdata[31:0], 32'h12345678);
      chk("rw_p1", rdata[63:32], 32'h12345678);
      rd(5'd7, 5'd3);
      chk("rw_p0_r7", rdata[31:0], 32'h12345678);
      chk("rw_p1_r3", rdata[63:32], 32'h0);

      // 3. zero register ignores write and issue, also in the same cycle
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
      issue_en = 1'b1; issue_addr = 5'd0;
      rd(5'd0, 5'd7);
      chk("zero_same_cycle", rdata[31:0], 32'h0);
      step();
      idle();
      rd(5'd0, 5'd0);
      chk("zero_rdata", rdata[31:0], 32'h0);
      chk("zero_rbusy", {31'd0, rbusy[0]}, 32'd0);
      chk("zero_anybusy", {31'd0, any_busy}, 32'd0);

      // 4. scoreboard set then clear on writeback
      issue_en = 1'b1; issue_addr = 5'd9;
      step();
      idle();
      rd(5'd9, 5'd1);
      chk("sb_set_rbusy", {31'd0, rbusy[0]}, 32'd1);
      chk("sb_set_other", {31'd0, rbusy[1]}, 32'd0);
      chk("sb_set_anybusy", {31'd0, any_busy}, 32'd1);
      step();
      chk("sb_hold_rbusy", {31'd0, rbusy[0]}, 32'd1);
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
      step();
      idle();
      rd(5'd9, 5'd9);
      chk("sb_clr_rbusy", {31'd0, rbusy[0]}, 32'd0);
      chk("sb_clr_anybusy", {31'd0, any_busy}, 32'd0);
      chk("sb_clr_rdata", rdata[31:0], 32'hA5A5A5A5);

      // 5a. same-address issue and writeback: set wins, data still written
      issue_en = 1'b1; issue_addr = 5'd4;
      step();
      issue_en = 1'b1; issue_addr = 5'd4;
      we = 1'b1; waddr = 5'd4; wdata = 32'h00000011;
      step();
      idle();
      rd(5'd4, 5'd4);
      chk("sim_same_busy", {31'd0, rbusy[0]}, 32'd1);
      chk("sim_same_rdata", rdata[63:32], 32'h00000011);
      // 5b. different addresses: r6 clears while r2 sets
      issue_en = 1'b1; issue_addr = 5'd6;
      step();
      issue_en = 1'b1; issue_addr = 5'd2;
      we = 1'b1; waddr = 5'd6; wdata = 32'h00000066;
      step();
      idle();
      rd(5'd2, 5'd6);
      chk("sim_diff_busy2", {31'd0, rbusy[0]}, 32'd1);
      chk("sim_diff_busy6", {31'd0, rbusy[1]}, 32'd0);
      chk("sim_diff_rdata6", rdata[63:32], 32'h00000066);
      chk("sim_diff_anybusy", {31'd0, any_busy}, 32'd1);

      // 6. write r10 while reading it in the same cycle (r10 holds 0x55 and is busy)
      issue_en = 1'b1; issue_addr = 5'd10;
      we = 1'b1; waddr = 5'd10; wdata = 32'h00000055;
      step();
      idle();
      rd(5'd10, 5'd3);
      chk("byp_pre_rdata", rdata[31:0], 32'h00000055);
      chk("byp_pre_rbusy", {31'd0, rbusy[0]}, 32'd1);
      we = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D;
      rd(5'd10, 5'd10);
`ifdef REGFILE_SB_BYPASS_EN
      chk("byp_same_rdata0", rdata[31:0], 32'hCAFEF00D);
      chk("byp_same_rdata1", rdata[63:32], 32'hCAFEF00D);
      chk("byp_same_rbusy0", {31'd0, rbusy[0]}, 32'd0);
`else
      chk("nobyp_same_rdata0", rdata[31:0], 32'h00000055);
      chk("nobyp_same_rdata1", rdata[63:32], 32'h00000055);
      chk("nobyp_same_rbusy0", {31'd0, rbusy[0]}, 32'd1);
`endif
      step();
      idle();
      rd(5'd10, 5'd4);
      chk("byp_next_rdata", rdata[31:0], 32'hCAFEF00D);
      chk("byp_next_rbusy", {31'd0, rbusy[0]}, 32'd0);
      chk("byp_other_r4", rdata[63:32], 32'h00000011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
